// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the
// command sequencer state encoding.
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'd0;
   localparam logic [5:0] OP_SUB = 6'd1;
   localparam logic [5:0] OP_AND = 6'd2;
   localparam logic [5:0] OP_OR  = 6'd3;
   localparam logic [5:0] OP_XOR = 6'd4;
   localparam logic [5:0] OP_NOT = 6'd5;
   localparam logic [5:0] OP_SHL = 6'd7;
   localparam logic [5:0] OP_SHR = 6'd8;
   localparam logic [5:0] OP_SAR = 6'd9;
   localparam logic [5:0] OP_ROL = 6'd10;
   localparam logic [5:0] OP_ROR = 6'd11;
   localparam logic [5:0] OP_INC = 6'd12;
   localparam logic [5:0] OP_DEC = 6'd13;
   localparam logic [5:0] OP_NEG = 6'd14;
   localparam logic [5:0] OP_CMP = 6'd15;
   localparam logic [5:0] OP_TST = 6'd16;
   localparam logic [5:0] OP_MUL = 6'd17;
   localparam logic [5:0] OP_MOV = 6'd18;
   localparam logic [5:0] OP_CLR = 6'd19;
   localparam logic [5:0] OP_SET = 6'd20;

   // rsp_flags layout is {OF,CF,SF,ZF}
   localparam int FLAG_ZF = 0;
   localparam int FLAG_SF = 1;
   localparam int FLAG_CF = 2;
   localparam int FLAG_OF = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_t;

   // Encoding 6 is a hole in the opcode map; everything above SET is unused.
   function automatic logic op_is_valid(input logic [5:0] op);
      return (op <= OP_SET) && (op != 6'd6);
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Sequences commands into an external combinational ALU: register operands,
// capture the ALU output one cycle later, and hold it until the consumer takes it.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int SEQ_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [5:0]       cmd_opcode,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic             cmd_carry_in,
   input  logic             cmd_chain,
   input  logic             cmd_use_cf,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [5:0]       alu_opcode,
   output logic             alu_carry_in,
   input  logic [31:0]      alu_result,
   input  logic             alu_zf,
   input  logic             alu_sf,
   input  logic             alu_cf,
   input  logic             alu_of,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_err,
   output logic [SEQ_W-1:0] rsp_seq
);

   seq_state_t       state, state_nxt;
   logic [SEQ_W-1:0] seq_cnt;
   logic [31:0]      last_res;
   logic             last_cf;
   logic             have_res;
   logic [3:0]       alu_flags;
   logic             accept;

   always_comb begin
      alu_flags          = '0;
      alu_flags[FLAG_ZF] = alu_zf;
      alu_flags[FLAG_SF] = alu_sf;
      alu_flags[FLAG_CF] = alu_cf;
      alu_flags[FLAG_OF] = alu_of;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            accept    = cmd_valid;
            if (cmd_valid) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_HOLD;
         ST_HOLD: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         seq_cnt      <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_opcode   <= '0;
         alu_carry_in <= 1'b0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
         rsp_err      <= 1'b0;
         rsp_seq      <= '0;
         last_res     <= '0;
         last_cf      <= 1'b0;
         have_res     <= 1'b0;
      end else begin
         state <= state_nxt;
         // err and seq are known at acceptance and cannot change before HOLD
         if (accept) begin
            alu_a        <= cmd_chain ? (have_res ? last_res : 32'd0) : cmd_a;
            alu_b        <= cmd_b;
            alu_opcode   <= cmd_opcode;
            alu_carry_in <= cmd_use_cf ? (have_res & last_cf) : cmd_carry_in;
            rsp_err      <= ~op_is_valid(cmd_opcode);
            rsp_seq      <= seq_cnt;
            seq_cnt      <= seq_cnt + 1'b1;
         end
         if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            last_res   <= alu_result;
            last_cf    <= alu_cf;
            have_res   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the alu_* side, directed
// commands feeding an expectation queue, and a monitor checking each response.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int SEQ_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [5:0]       cmd_opcode = '0;
   logic [31:0]      cmd_a = '0;
   logic [31:0]      cmd_b = '0;
   logic             cmd_carry_in = 1'b0;
   logic             cmd_chain = 1'b0;
   logic             cmd_use_cf = 1'b0;
   logic [31:0]      alu_a, alu_b;
   logic [5:0]       alu_opcode;
   logic             alu_carry_in;
   logic [31:0]      alu_result;
   logic             alu_zf, alu_sf, alu_cf, alu_of;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [31:0]      rsp_result;
   logic [3:0]       rsp_flags;
   logic             rsp_err;
   logic [SEQ_W-1:0] rsp_seq;

   alu_cmd_sequencer #(.SEQ_W(SEQ_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_carry_in(cmd_carry_in), .cmd_chain(cmd_chain), .cmd_use_cf(cmd_use_cf),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in),
      .alu_result(alu_result), .alu_zf(alu_zf), .alu_sf(alu_sf),
      .alu_cf(alu_cf), .alu_of(alu_of),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_err(rsp_err), .rsp_seq(rsp_seq)
   );

   always #5 clk = ~clk;

   // Stand-in for the external ALU (only the opcodes the bench exercises)
   always_comb begin
      logic [32:0] wide;
      wide   = '0;
      alu_cf = 1'b0;
      alu_of = 1'b0;
      case (alu_opcode)
         OP_ADD: begin
            wide   = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry_in};
            alu_cf = wide[32];
            alu_of = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
         end
         OP_SUB: begin
            wide   = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_carry_in};
            alu_cf = wide[32];
            alu_of = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
         end
         OP_AND:  wide = {1'b0, alu_a & alu_b};
         OP_OR:   wide = {1'b0, alu_a | alu_b};
         OP_XOR:  wide = {1'b0, alu_a ^ alu_b};
         OP_SET:  wide = {1'b0, 32'hFFFF_FFFF};
         default: wide = '0;
      endcase
      alu_result = wide[31:0];
      alu_zf     = (wide[31:0] == 32'd0);
      alu_sf     = wide[31];
   end

   typedef struct {
      logic [31:0]      res;
      logic [3:0]       flags;
      logic             err;
      logic [SEQ_W-1:0] seq;
      int               acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every response handshake must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flags});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_seq", {24'd0, rsp_seq}, {24'd0, e.seq});
            if (e.acc_cyc >= 0) chk("latency", cyc - e.acc_cyc, 32'd2);
         end
      end
   end

   // Present one command and return one cycle after it is accepted.
   task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic chain, input logic use_cf,
                       input logic push, input logic [31:0] res, input logic [3:0] flags,
                       input logic err, input logic [SEQ_W-1:0] seq, input logic lat);
      exp_t e;
      bit   done;
      done = 0;
      @(posedge clk); #1;
      cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_carry_in = ci;
      cmd_chain = chain; cmd_use_cf = use_cf; cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            done = 1;
            if (push) begin
               e.res = res; e.flags = flags; e.err = err; e.seq = seq;
               e.acc_cyc = lat ? cyc : -1;
               exp_q.push_back(e);
            end
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_pending", exp_q.size(), 32'd0);
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_result", rsp_result, 32'd0);
      chk("reset_rsp_flags", {28'd0, rsp_flags}, 32'd0);
      chk("reset_rsp_err_seq", {23'd0, rsp_err, rsp_seq}, 32'd0);
      chk("reset_alu_regs", alu_a | alu_b | {26'd0, alu_opcode} | {31'd0, alu_carry_in}, 32'd0);

      // Basic arithmetic, chaining and carry forwarding
      send(OP_ADD, 32'd10, 32'd5, 0, 0, 0, 1, 32'd15, 4'b0000, 0, 8'd0, 1);
      send(OP_SUB, 32'd10, 32'd5, 0, 0, 0, 1, 32'd5,  4'b0000, 0, 8'd1, 1);
      send(OP_SUB, 32'd99, 32'd5, 0, 1, 0, 1, 32'd0,  4'b0001, 0, 8'd2, 1);
      send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1, 32'd0, 4'b0101, 0, 8'd3, 1);
      send(OP_ADD, 32'd0, 32'd0, 0, 0, 1, 1, 32'd1, 4'b0000, 0, 8'd4, 1);
      // Opcode legality: 6 and 63 flagged, 20 is SET and legal
      send(6'd6,   32'd3, 32'd4, 0, 0, 0, 1, 32'd0, 4'b0001, 1, 8'd5, 1);
      send(6'd63,  32'd3, 32'd4, 0, 0, 0, 1, 32'd0, 4'b0001, 1, 8'd6, 1);
      send(6'd20,  32'd3, 32'd4, 0, 0, 0, 1, 32'hFFFF_FFFF, 4'b0010, 0, 8'd7, 1);
      send(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 0, 1, 32'h0000_F000, 4'b0000, 0, 8'd8, 1);
      drain();

      // Backpressure: response held, stray command ignored
      rsp_ready = 1'b0;
      send(OP_ADD, 32'd1, 32'd2, 0, 0, 0, 1, 32'd3, 4'b0000, 0, 8'd9, 0);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      chk("hold_rsp_valid_seen", {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
      cmd_opcode = OP_ADD; cmd_a = 32'd100; cmd_b = 32'd100; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         chk("hold_result", rsp_result, 32'd3);
         chk("hold_seq", {24'd0, rsp_seq}, 32'd9);
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(posedge clk); #1 rsp_ready = 1'b1;
      send(OP_ADD, 32'd7, 32'd1, 0, 0, 0, 1, 32'd8, 4'b0000, 0, 8'd10, 1);
      drain();

      // Reset during EXEC drops the command; chain afterwards sees A=0
      send(OP_ADD, 32'd50, 32'd50, 0, 0, 0, 0, 32'd0, 4'b0, 0, 8'd0, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_exec_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      send(OP_ADD, 32'd123, 32'd7, 0, 1, 0, 1, 32'd7, 4'b0000, 0, 8'd0, 1);
      drain();

      // Sequence tag wraps after 256 commands
      do_reset();
      for (int i = 0; i < 257; i++)
         send(OP_ADD, i, 32'd1, 0, 0, 0, 1, i + 1, 4'b0000, 0, i[SEQ_W-1:0], 1);
      drain();

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
